mux4_rr_arbiter: RTL and testbench

- Shares the 4-bit 2:1 mux datapath between two requesters (port 0 and port 1) using round-robin arbitration with bounded bursts.
- Drives the mux select and forwards the selected nibble to one downstream consumer over a valid/ready handshake.
- Sits between two nibble producers and a single consumer.
- Select polarity matches the existing datapath: sel=1 passes port 0, sel=0 passes port 1.

---
 rtl/mux4_rr_arbiter_pkg.sv | 19 +
 rtl/mux4_rr_arbiter_if.sv | 38 +++
 rtl/mux4_2to1.sv | 9 +
 rtl/mux4_burst_cnt.sv | 30 +++
 rtl/mux4_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 185 ++++++++++++++++++
 6 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared encodings for the round-robin nibble arbiter: FSM states, mux select polarity, defaults.
package mux4_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // The existing datapath passes port 0 when its select is high.
    localparam logic SEL_PORT0 = 1'b1;
    localparam logic SEL_PORT1 = 1'b0;

    localparam logic LAST_P0 = 1'b0;
    localparam logic LAST_P1 = 1'b1;

    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between the two producers, the arbiter and the consumer.
// Per-port beat counters and their clear exist only when MUX4_ARB_STATS_EN is defined.
interface mux4_rr_arbiter_if;
    logic       req0;
    logic [3:0] data0;
    logic       ack0;
    logic       req1;
    logic [3:0] data1;
    logic       ack1;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       sel;
    logic       busy;
`ifdef MUX4_ARB_STATS_EN
    logic       stats_clr;
    logic [7:0] gcnt0;
    logic [7:0] gcnt1;

    modport slave (
        input  req0, data0, req1, data1, out_ready, stats_clr,
        output ack0, ack1, out_valid, out_data, sel, busy, gcnt0, gcnt1
    );
    modport master (
        output req0, data0, req1, data1, out_ready, stats_clr,
        input  ack0, ack1, out_valid, out_data, sel, busy, gcnt0, gcnt1
    );
`else
    modport slave (
        input  req0, data0, req1, data1, out_ready,
        output ack0, ack1, out_valid, out_data, sel, busy
    );
    modport master (
        output req0, data0, req1, data1, out_ready,
        input  ack0, ack1, out_valid, out_data, sel, busy
    );
`endif
endinterface

// File: rtl/mux4_2to1.sv
// Existing 4-bit 2:1 nibble mux datapath; sel_i high passes a_i.
module mux4_2to1 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       sel_i,
    output logic [3:0] y_o
);
    assign y_o = sel_i ? a_i : b_i;
endmodule

// File: rtl/mux4_burst_cnt.sv
// Beats-per-grant counter; clear dominates increment, done_o flags the last beat of a burst.
module mux4_burst_cnt #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic done_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == CNT_W'(MAX_BURST - 1));
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the nibble mux between two producers; 1-cycle req-to-valid.
// Stalls hold grant and count; MUX4_ARB_STATS_EN adds saturating per-port beat counters.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = 4
) (
    input  logic                clk,
    input  logic                rst,
    mux4_rr_arbiter_if.slave    bus
);
    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   last_q, last_d;
    logic   cnt_inc, cnt_clr, cnt_done;
    logic   req_g, xfer, burst_end;

    // Request of whichever port currently holds the grant; zero in IDLE.
    assign req_g     = ((state_q == GNT0) & bus.req0) | ((state_q == GNT1) & bus.req1);
    assign xfer      = req_g & bus.out_ready;
    assign burst_end = (state_q != IDLE) & ((xfer & cnt_done) | ~req_g);

    assign bus.out_valid = req_g;
    assign bus.ack0      = xfer & (state_q == GNT0);
    assign bus.ack1      = xfer & (state_q == GNT1);
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_inc = xfer;
        cnt_clr = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                // On a tie the port that did not own the previous burst wins.
                if (bus.req0 && (!bus.req1 || last_q == LAST_P1)) begin
                    state_d = GNT0;
                    sel_d   = SEL_PORT0;
                end else if (bus.req1) begin
                    state_d = GNT1;
                    sel_d   = SEL_PORT1;
                end
            end
            GNT0: begin
                if (burst_end) begin
                    last_d  = LAST_P0;
                    cnt_clr = 1'b1;
                    if (bus.req1) begin
                        state_d = GNT1;
                        sel_d   = SEL_PORT1;
                    end else if (!bus.req0) begin
                        state_d = IDLE;
                    end
                end
            end
            GNT1: begin
                if (burst_end) begin
                    last_d  = LAST_P1;
                    cnt_clr = 1'b1;
                    if (bus.req0) begin
                        state_d = GNT0;
                        sel_d   = SEL_PORT0;
                    end else if (!bus.req1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_PORT0;
            last_q  <= LAST_P1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    mux4_burst_cnt #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_burst_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .done_o (cnt_done)
    );

    mux4_2to1 u_mux (
        .a_i   (bus.data0),
        .b_i   (bus.data1),
        .sel_i (sel_q),
        .y_o   (bus.out_data)
    );

`ifdef MUX4_ARB_STATS_EN
    logic [7:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d;

    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        if (bus.stats_clr) begin
            gcnt0_d = '0;
            gcnt1_d = '0;
        end else begin
            if (bus.ack0 && gcnt0_q != 8'hFF) gcnt0_d = gcnt0_q + 8'd1;
            if (bus.ack1 && gcnt1_q != 8'hFF) gcnt1_d = gcnt1_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
        end
    end

    assign bus.gcnt0 = gcnt0_q;
    assign bus.gcnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed phases push expected beats, a monitor pops on transfers.
module tb_mux4_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(
        .MAX_BURST (4),
        .CNT_W     (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       port;
        logic [3:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input logic p, input logic [3:0] d, input int n);
        beat_t b;
        b.port = p;
        b.data = d;
        repeat (n) exp_q.push_back(b);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted beat against the head of the expected queue.
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            chk("dual_ack", int'(bus.ack0 & bus.ack1), 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", int'(bus.out_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", int'(bus.out_data), int'(e.data));
                    chk("beat_sel",  int'(bus.sel),  e.port ? 0 : 1);
                    chk("beat_ack0", int'(bus.ack0), e.port ? 0 : 1);
                    chk("beat_ack1", int'(bus.ack1), e.port ? 1 : 0);
                end
            end else begin
                chk("no_xfer_ack", int'(bus.ack0 | bus.ack1), 0);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.data0     = 4'h0;
        bus.data1     = 4'h0;
        bus.out_ready = 1'b0;
`ifdef MUX4_ARB_STATS_EN
        bus.stats_clr = 1'b0;
`endif
        #2;
        chk("por_valid", int'(bus.out_valid), 0);
        chk("por_sel",   int'(bus.sel),       1);
        chk("por_busy",  int'(bus.busy),      0);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Single requester: 8 beats of 4'hA, regranted after each 4-beat burst without a gap.
        push(1'b0, 4'hA, 8);
        bus.data0 = 4'hA; bus.out_ready = 1'b1; bus.req0 = 1'b1;
        @(negedge clk);
        chk("lat_idle_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        chk("lat_valid", int'(bus.out_valid), 1);
        chk("lat_sel",   int'(bus.sel),       1);
        tick(8);
        bus.req0 = 1'b0;
        chk("single_beats_left", exp_q.size(), 0);
        tick(2);

        // Contention after reset: port 0 first, bursts of 4 alternating, no bubble.
        rst = 1'b1; #1; rst = 1'b0;
        push(1'b0, 4'h3, 4); push(1'b1, 4'hC, 4);
        push(1'b0, 4'h3, 4); push(1'b1, 4'hC, 4);
        bus.data0 = 4'h3; bus.data1 = 4'hC; bus.req0 = 1'b1; bus.req1 = 1'b1;
        tick(17);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("contend_beats_left", exp_q.size(), 0);
        tick(2);

        // Backpressure: GNT0 stalled 5 cycles while port 1 waits.
        bus.data0 = 4'h5; bus.data1 = 4'h9; bus.out_ready = 1'b0; bus.req0 = 1'b1;
        tick(1);
        bus.req1 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_ack0",  int'(bus.ack0),      0);
            chk("stall_sel",   int'(bus.sel),       1);
            chk("stall_busy",  int'(bus.busy),      1);
        end
        tick(1);
        push(1'b0, 4'h5, 4); push(1'b1, 4'h9, 2);
        bus.out_ready = 1'b1;
        tick(6);
        chk("stall_beats_left", exp_q.size(), 0);

        // Asynchronous reset mid-burst (GNT1, cnt=2): outputs clear with no clock edge.
        rst = 1'b1;
        #1;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_ack0",  int'(bus.ack0),      0);
        chk("rst_ack1",  int'(bus.ack1),      0);
        chk("rst_sel",   int'(bus.sel),       1);
        chk("rst_busy",  int'(bus.busy),      0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);

        // Early drop: port 1 drops after one beat, port 0 takes over next cycle.
        push(1'b1, 4'h6, 1); push(1'b0, 4'h7, 1);
        bus.data1 = 4'h6; bus.data0 = 4'h7; bus.req1 = 1'b1;
        tick(1);
        bus.req0 = 1'b1;
        tick(1);
        bus.req1 = 1'b0;
        @(negedge clk);
        chk("drop_valid", int'(bus.out_valid), 0);
        @(negedge clk);
        chk("drop_next_sel",   int'(bus.sel),       1);
        chk("drop_next_busy",  int'(bus.busy),      1);
        chk("drop_next_valid", int'(bus.out_valid), 1);
        tick(1);
        bus.req0 = 1'b0;
        chk("drop_beats_left", exp_q.size(), 0);
        tick(2);

`ifdef MUX4_ARB_STATS_EN
        rst = 1'b1; #1; rst = 1'b0;
        chk("stats_rst_gcnt0", int'(bus.gcnt0), 0);
        push(1'b0, 4'h7, 300);
        bus.req0 = 1'b1;
        tick(301);
        bus.req0 = 1'b0;
        chk("stats_sat_gcnt0", int'(bus.gcnt0), 255);
        chk("stats_gcnt1",     int'(bus.gcnt1), 0);
        chk("stats_beats_left", exp_q.size(), 0);
        tick(2);
        push(1'b0, 4'h7, 1);
        bus.req0 = 1'b1;
        tick(1);
        bus.stats_clr = 1'b1;
        tick(1);
        bus.stats_clr = 1'b0;
        bus.req0 = 1'b0;
        chk("stats_clr_gcnt0", int'(bus.gcnt0), 0);
        tick(2);
`endif

        chk("final_beats_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
